control_unit: RTL and testbench

Hardwired Moore-style sequencer that sits directly upstream of DataPath and drives every DataPath control strobe. It steps each instruction through a common three-cycle fetch (T0–T2) and then an opcode-specific execute sequence (T3–T7). It also provides the run/clear status for the top level.

---
 rtl/cpu_defs.sv | 45 ++++
 rtl/opcode_decode.sv | 32 +++
 rtl/control_unit.sv | 128 ++++++++++++
 tb/tb_control_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, ALU add code, sequencer states, decode
// classes and the control-strobe bundle driven into DataPath.
package cpu_defs;

   localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JAL  = 5'b10100;
   localparam logic [4:0] OP_JR   = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFLO = 5'b11000, OP_MFHI = 5'b11001, OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // ALU code used for address, branch-target and PC-increment arithmetic
   localparam logic [4:0] ALU_ADD = OP_ADD;

   typedef enum logic [3:0] {
      ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
   } state_e;

   typedef struct packed {
      logic rtype, imm, unary, muldiv, ld, ldi, st, br, jr, jal, io, mf, nop, halt;
   } iclass_t;

   typedef struct packed {
      logic       PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
      logic       Gra, Grb, Grc, Rin, Rout, BAout, Cout, jal_flag;
      logic       Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, CONin;
      logic       InPortOut, OutPortIn;
      logic [4:0] alu_op;
      logic       clear, run;
   } ctrl_t;

   // Immediate forms reuse the register-form ALU operation
   function automatic logic [4:0] imm_alu(input logic [4:0] op);
      case (op)
         OP_ANDI: imm_alu = OP_AND;
         OP_ORI:  imm_alu = OP_OR;
         default: imm_alu = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/opcode_decode.sv
// Maps the 5-bit opcode to a one-hot instruction class used for sequencing.
module opcode_decode
   import cpu_defs::*;
(
   input  logic [4:0] opcode_i,
   output iclass_t    cls_o
);

   always_comb begin
      cls_o = '0;
      case (opcode_i)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
         OP_SHR, OP_SHRA, OP_SHL:        cls_o.rtype  = 1'b1;
         OP_ADDI, OP_ANDI, OP_ORI:       cls_o.imm    = 1'b1;
         OP_NEG, OP_NOT:                 cls_o.unary  = 1'b1;
         OP_DIV, OP_MUL:                 cls_o.muldiv = 1'b1;
         OP_LD:                          cls_o.ld     = 1'b1;
         OP_LDI:                         cls_o.ldi    = 1'b1;
         OP_ST:                          cls_o.st     = 1'b1;
         OP_BR:                          cls_o.br     = 1'b1;
         OP_JR:                          cls_o.jr     = 1'b1;
         OP_JAL:                         cls_o.jal    = 1'b1;
         OP_IN, OP_OUT:                  cls_o.io     = 1'b1;
         OP_MFLO, OP_MFHI:               cls_o.mf     = 1'b1;
         OP_HALT:                        cls_o.halt   = 1'b1;
         OP_NOP:                         cls_o.nop    = 1'b1;
         // unassigned opcodes behave as nop
         default:                        cls_o.nop    = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: shared fetch T0-T2, class-specific execute T3-T7,
// strobes decoded from the registered state and the IR.
module control_unit
   import cpu_defs::*;
#(
   parameter logic [4:0] ADD_OP = ALU_ADD
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        stop,
   input  logic [31:0] ir,
   input  logic        con_ff,
   output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
   output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, jal_flag,
   output logic        Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, CONin,
   output logic        InPortOut, OutPortIn,
   output logic [4:0]  alu_op,
   output logic        clear,
   output logic        run
);

   state_e     state_q, state_d;
   logic       stop_pend_q;
   logic       end_instr;
   iclass_t    cls;
   ctrl_t      c;
   logic [4:0] op;
   logic       unused_ir;

   assign op        = ir[31:27];
   assign unused_ir = ^ir[26:0];

   opcode_decode u_dec (.opcode_i(op), .cls_o(cls));

   always_comb begin
      state_d   = state_q;
      end_instr = 1'b0;
      case (state_q)
         ST_RESET: end_instr = 1'b1;
         ST_T0:    state_d = ST_T1;
         ST_T1:    state_d = ST_T2;
         ST_T2:    state_d = ST_T3;
         ST_T3:    if (cls.halt) state_d = ST_HALT;
                   else if (cls.jr | cls.io | cls.mf | cls.nop) end_instr = 1'b1;
                   else state_d = ST_T4;
         ST_T4:    if (cls.unary | cls.jal) end_instr = 1'b1; else state_d = ST_T5;
         ST_T5:    if (cls.rtype | cls.imm | cls.ldi) end_instr = 1'b1; else state_d = ST_T6;
         ST_T6:    if (cls.muldiv | cls.br) end_instr = 1'b1; else state_d = ST_T7;
         ST_T7:    end_instr = 1'b1;
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_RESET;
      endcase
      // a stop seen at any point is honoured at the next instruction boundary
      if (end_instr) state_d = (stop | stop_pend_q) ? ST_HALT : ST_T0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_RESET;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         stop_pend_q <= stop_pend_q | stop;
      end
   end

   always_comb begin
      c = '0;
      case (state_q)
         ST_RESET: c.clear = 1'b1;
         ST_HALT:  ;
         ST_T0: begin c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; c.Zin = 1'b1; c.alu_op = ADD_OP; end
         ST_T1: begin c.ZLowOut = 1'b1; c.PCin = 1'b1; c.Read = 1'b1; c.MDRin = 1'b1; end
         ST_T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
         ST_T3: begin
            if (cls.rtype | cls.imm) begin c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
            if (cls.unary)  begin c.Grb = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; c.alu_op = op; end
            if (cls.muldiv) begin c.Gra = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
            if (cls.ld | cls.ldi | cls.st) begin c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1; end
            if (cls.br)  begin c.Gra = 1'b1; c.Rout = 1'b1; c.CONin = 1'b1; end
            if (cls.jr)  begin c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1; end
            if (cls.jal) begin c.PCout = 1'b1; c.Rin = 1'b1; c.jal_flag = 1'b1; end
            if (cls.io) begin
               c.Gra = 1'b1;
               if (op == OP_IN) begin c.InPortOut = 1'b1; c.Rin = 1'b1; end
               else begin c.Rout = 1'b1; c.OutPortIn = 1'b1; end
            end
            if (cls.mf) begin
               c.Gra = 1'b1; c.Rin = 1'b1;
               if (op == OP_MFLO) c.LOout = 1'b1; else c.HIout = 1'b1;
            end
         end
         ST_T4: begin
            if (cls.rtype)  begin c.Grc = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; c.alu_op = op; end
            if (cls.imm)    begin c.Cout = 1'b1; c.Zin = 1'b1; c.alu_op = imm_alu(op); end
            if (cls.unary)  begin c.ZLowOut = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
            if (cls.muldiv) begin c.Grb = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; c.alu_op = op; end
            if (cls.ld | cls.ldi | cls.st) begin c.Cout = 1'b1; c.Zin = 1'b1; c.alu_op = ADD_OP; end
            if (cls.br)     begin c.PCout = 1'b1; c.Yin = 1'b1; end
            if (cls.jal)    begin c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1; end
         end
         ST_T5: begin
            if (cls.rtype | cls.imm | cls.ldi) begin c.ZLowOut = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
            if (cls.muldiv)     begin c.ZLowOut = 1'b1; c.LOin = 1'b1; end
            if (cls.ld | cls.st) begin c.ZLowOut = 1'b1; c.MARin = 1'b1; end
            if (cls.br)         begin c.Cout = 1'b1; c.Zin = 1'b1; c.alu_op = ADD_OP; end
         end
         ST_T6: begin
            if (cls.muldiv) begin c.ZHighOut = 1'b1; c.HIin = 1'b1; end
            if (cls.ld)     begin c.Read = 1'b1; c.MDRin = 1'b1; end
            if (cls.st)     begin c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1; end
            if (cls.br)     begin c.ZLowOut = 1'b1; c.PCin = con_ff; end
         end
         ST_T7: begin
            if (cls.ld) begin c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
            if (cls.st) c.Write = 1'b1;
         end
         default: ;
      endcase
      c.run = (state_q != ST_RESET) && (state_q != ST_HALT);
   end

   assign {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
           Gra, Grb, Grc, Rin, Rout, BAout, Cout, jal_flag,
           Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, CONin,
           InPortOut, OutPortIn, alu_op, clear, run} = c;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction step-table model compared
// every cycle, plus hand-computed probes at the interesting steps.
module tb_control_unit;

   logic        clock = 1'b0;
   logic        reset, stop, con_ff;
   logic [31:0] ir;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
   logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, jal_flag;
   logic Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, CONin;
   logic InPortOut, OutPortIn, clear, run;
   logic [4:0] alu_op;

   always #5 clock = ~clock;

   control_unit dut (
      .clock(clock), .reset(reset), .stop(stop), .ir(ir), .con_ff(con_ff),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .Cout(Cout), .jal_flag(jal_flag), .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut),
      .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
      .CONin(CONin), .InPortOut(InPortOut), .OutPortIn(OutPortIn),
      .alu_op(alu_op), .clear(clear), .run(run)
   );

   typedef struct packed {
      logic       PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
      logic       Gra, Grb, Grc, Rin, Rout, BAout, Cout, jal_flag;
      logic       Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, CONin;
      logic       InPortOut, OutPortIn;
      logic [4:0] alu_op;
      logic       clear, run;
   } sig_t;

   sig_t got, want;
   assign got = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
                 Gra, Grb, Grc, Rin, Rout, BAout, Cout, jal_flag,
                 Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout, CONin,
                 InPortOut, OutPortIn, alu_op, clear, run};

   int checks = 0, errors = 0;

   // Instruction length in cycles, fetch included
   function automatic int lat(input logic [4:0] op);
      if (op inside {[3:14], 5'd1}) return 6;
      if (op inside {5'd17, 5'd18, 5'd20}) return 5;
      if (op inside {5'd15, 5'd16, 5'd19}) return 7;
      if (op inside {5'd0, 5'd2}) return 8;
      return 4;
   endfunction

   // Expected strobes for mode (0 reset, 1 running, 2 halted) and step 0..7
   function automatic sig_t model_out(input int m, input int s, input logic [4:0] op, input logic cf);
      sig_t e = '0;
      if (m == 0) begin e.clear = 1'b1; return e; end
      if (m == 2) return e;
      e.run = 1'b1;
      if (s == 0) begin e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1; e.alu_op = 5'd3; return e; end
      if (s == 1) begin e.ZLowOut = 1; e.PCin = 1; e.Read = 1; e.MDRin = 1; return e; end
      if (s == 2) begin e.MDRout = 1; e.IRin = 1; return e; end
      if (op inside {[3:14]}) begin
         if (s == 3) begin e.Grb = 1; e.Rout = 1; e.Yin = 1; end
         if (s == 4 && op <= 11) begin e.Grc = 1; e.Rout = 1; e.Zin = 1; e.alu_op = op; end
         if (s == 4 && op >= 12) begin
            e.Cout = 1; e.Zin = 1; e.alu_op = (op == 12) ? 5'd3 : (op == 13) ? 5'd5 : 5'd6;
         end
         if (s == 5) begin e.ZLowOut = 1; e.Gra = 1; e.Rin = 1; end
      end else if (op == 17 || op == 18) begin
         if (s == 3) begin e.Grb = 1; e.Rout = 1; e.Zin = 1; e.alu_op = op; end
         if (s == 4) begin e.ZLowOut = 1; e.Gra = 1; e.Rin = 1; end
      end else if (op == 15 || op == 16) begin
         if (s == 3) begin e.Gra = 1; e.Rout = 1; e.Yin = 1; end
         if (s == 4) begin e.Grb = 1; e.Rout = 1; e.Zin = 1; e.alu_op = op; end
         if (s == 5) begin e.ZLowOut = 1; e.LOin = 1; end
         if (s == 6) begin e.ZHighOut = 1; e.HIin = 1; end
      end else if (op <= 2) begin
         if (s == 3) begin e.Grb = 1; e.BAout = 1; e.Yin = 1; end
         if (s == 4) begin e.Cout = 1; e.Zin = 1; e.alu_op = 5'd3; end
         if (s == 5 && op == 1) begin e.ZLowOut = 1; e.Gra = 1; e.Rin = 1; end
         if (s == 5 && op != 1) begin e.ZLowOut = 1; e.MARin = 1; end
         if (s == 6 && op == 0) begin e.Read = 1; e.MDRin = 1; end
         if (s == 6 && op == 2) begin e.Gra = 1; e.Rout = 1; e.MDRin = 1; end
         if (s == 7 && op == 0) begin e.MDRout = 1; e.Gra = 1; e.Rin = 1; end
         if (s == 7 && op == 2) e.Write = 1;
      end else if (op == 19) begin
         if (s == 3) begin e.Gra = 1; e.Rout = 1; e.CONin = 1; end
         if (s == 4) begin e.PCout = 1; e.Yin = 1; end
         if (s == 5) begin e.Cout = 1; e.Zin = 1; e.alu_op = 5'd3; end
         if (s == 6) begin e.ZLowOut = 1; e.PCin = cf; end
      end else if (op == 20) begin
         if (s == 3) begin e.PCout = 1; e.Rin = 1; e.jal_flag = 1; end
         if (s == 4) begin e.Gra = 1; e.Rout = 1; e.PCin = 1; end
      end else if (s == 3) begin
         case (op)
            5'd21: begin e.Gra = 1; e.Rout = 1; e.PCin = 1; end
            5'd22: begin e.InPortOut = 1; e.Gra = 1; e.Rin = 1; end
            5'd23: begin e.Gra = 1; e.Rout = 1; e.OutPortIn = 1; end
            5'd24: begin e.LOout = 1; e.Gra = 1; e.Rin = 1; end
            5'd25: begin e.HIout = 1; e.Gra = 1; e.Rin = 1; end
            default: ;
         endcase
      end
      return e;
   endfunction

   // Model progress: position within the current instruction
   int  mode = 0, step = 0;
   bit  pend = 0, chk_en = 0;

   always @(posedge clock) begin
      if (reset) begin
         mode <= 0; step <= 0; pend <= 0; chk_en <= 1;
      end else begin
         pend <= pend | stop;
         if (mode == 1 && step == 3 && ir[31:27] == 5'd27) mode <= 2;
         else if (mode == 0 || (mode == 1 && step == lat(ir[31:27]) - 1)) begin
            if (stop || pend) mode <= 2;
            else begin mode <= 1; step <= 0; end
         end else if (mode == 1) step <= step + 1;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         want = model_out(mode, step, ir[31:27], con_ff);
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL cycle mode=%0d step=%0d op=%b got=%h want=%h", mode, step, ir[31:27], got, want);
         end
      end
   end

   task automatic lit(input string nm, input logic [63:0] g, input logic [63:0] w);
      checks++;
      if (g !== w) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, g, w);
      end
   endtask

   // Called on the T0 negedge; returns on the next instruction's T0 negedge
   task automatic instr(input logic [31:0] v, input int n);
      ir = v;
      repeat (n) @(negedge clock);
   endtask

   logic [31:0] tbl_ir  [19] = '{32'h60880007, 32'h68880007, 32'h70880007, 32'h20918000,
                                 32'h38918000, 32'h58918000, 32'h88900000, 32'h90900000,
                                 32'h79100000, 32'h08800042, 32'hA0800000, 32'hA8800000,
                                 32'hB0800000, 32'hB8800000, 32'hC0800000, 32'hC8800000,
                                 32'hD0000000, 32'hE0000000, 32'hF8000000};
   int          tbl_lat [19] = '{6, 6, 6, 6, 6, 6, 5, 5, 7, 6, 5, 4, 4, 4, 4, 4, 4, 4, 4};

   initial begin
      reset = 1'b1; stop = 1'b0; ir = '0; con_ff = 1'b0;
      repeat (3) @(negedge clock);
      lit("rst_clear_run", {clear, run}, 2'b10);
      reset = 1'b0;
      @(negedge clock);
      lit("t0_after_reset", {PCout, MARin, IncPC, Zin, alu_op, run}, {4'b1111, 5'b00011, 1'b1});

      ir = 32'h18918000;
      repeat (3) @(negedge clock);
      lit("add_t3", {Grb, Rout, Yin, Zin}, 4'b1110);
      @(negedge clock);
      lit("add_t4", {Grc, Rout, Zin, alu_op}, {3'b111, 5'b00011});
      @(negedge clock);
      lit("add_t5", {ZLowOut, Gra, Rin, Rout}, 4'b1110);
      @(negedge clock);
      lit("add_next_t0", {PCout, IRin}, 2'b10);

      ir = 32'h00880005;
      repeat (6) @(negedge clock);
      lit("ld_t6", {Read, MDRin}, 2'b11);
      @(negedge clock);
      lit("ld_t7", {MDRout, Gra, Rin}, 3'b111);
      @(negedge clock);
      lit("ld_len8", PCout, 1'b1);

      ir = 32'h10880005;
      repeat (7) @(negedge clock);
      lit("st_t7", {Write, Read}, 2'b10);
      @(negedge clock);
      lit("st_len8", PCout, 1'b1);

      ir = 32'h98800002; con_ff = 1'b0;
      repeat (6) @(negedge clock);
      lit("br_nt_t6", {ZLowOut, PCin}, 2'b10);
      @(negedge clock);
      ir = 32'h98800002; con_ff = 1'b1;
      repeat (6) @(negedge clock);
      lit("br_t_t6", {ZLowOut, PCin}, 2'b11);
      @(negedge clock);
      con_ff = 1'b0;

      ir = 32'h81100000;
      repeat (5) @(negedge clock);
      lit("mul_t5", {LOin, HIin}, 2'b10);
      @(negedge clock);
      lit("mul_t6", {LOin, HIin}, 2'b01);
      @(negedge clock);
      lit("mul_t0", PCout, 1'b1);

      for (int i = 0; i < 19; i++) begin
         con_ff = i[0];
         instr(tbl_ir[i], tbl_lat[i]);
      end
      con_ff = 1'b0;

      // reset in the middle of an instruction
      ir = 32'h18918000;
      repeat (4) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      lit("midreset_clear", {clear, run, Zin}, 3'b100);
      reset = 1'b0;
      @(negedge clock);
      lit("midreset_t0", PCout, 1'b1);

      // stop pulsed during T4: add completes, then halt
      ir = 32'h18918000;
      repeat (4) @(negedge clock);
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      lit("stop_t5_runs", {ZLowOut, Gra, Rin, run}, 4'b1111);
      @(negedge clock);
      lit("stop_halt", got, '0);
      repeat (3) @(negedge clock);
      lit("stop_halt_held", got, '0);

      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      lit("recover_t0", {PCout, run}, 2'b11);

      ir = 32'hD8000000;
      repeat (3) @(negedge clock);
      lit("halt_op_t3", run, 1'b1);
      @(negedge clock);
      lit("halt_op_halted", got, '0);
      repeat (2) @(negedge clock);

      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      lit("recover2_t0", {PCout, clear}, 2'b10);
      instr(32'h18918000, 6);
      lit("final_t0", {PCout, run}, 2'b11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
